conv_stream_framer: RTL
=======================

// Module: conv_stream_framer
// PURPOSE
//  Downstream stage of the convolution kernel. Consumes its valid-qualified RGB pixel stream.
//  Tracks frame position (col/row) and blanks border pixels whose sliding window was incomplete.
//  Tags sof/eol/eof markers and buffers pixels in a first-word-fall-through FIFO.
//  The FIFO output uses a valid/ready handshake toward the display/memory writer.
// PARAMETERS
//  LINE_WIDTH    640  pixels per line
//  FRAME_HEIGHT  480  lines per frame
//  PIXEL_DEPTH   8    bits per colour channel
//  KERNEL_SIZE   3    convolution window size N; border = first N-1 cols and first N-1 rows
//  FIFO_DEPTH    16   output FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1              clock, all logic rising-edge
//  rst         in   1              synchronous active-high reset
//  sof_i       in   1              frame restart pulse: pixel accepted this cycle is (0,0)
//  valid_i     in   1              input pixel valid (from kernel valid_o)
//  input_R/G/B in   PIXEL_DEPTH    input channels
//  ready_i     in   1              consumer accepts output this cycle
//  valid_o     out  1              output pixel available (FIFO not empty)
//  output_R/G/B out PIXEL_DEPTH    head-of-FIFO channels
//  sof_o/eol_o/eof_o out 1         head pixel is (0,0) / last col / last col of last row
//  col_o       out  clog2(LINE_WIDTH)    column of next input pixel
//  row_o       out  clog2(FRAME_HEIGHT)  row of next input pixel
//  level_o     out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow_o  out  1              sticky: an input pixel was dropped
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides everything): col/row=0, FIFO emptied, level_o=0, valid_o=0.
//   Also on reset: output data and markers=0, overflow_o=0. Mid-frame reset discards FIFO contents.
//  Position: on each cycle with valid_i=1, col increments. At col=LINE_WIDTH-1 it wraps to 0 and row increments.
//   At row=FRAME_HEIGHT-1 with col wrap, row wraps to 0. valid_i=0: counters hold.
//  sof_i=1: position taken as (0,0) for this cycle. With valid_i=1 the next position is (1,0); with valid_i=0 it is (0,0).
//   sof_i also clears overflow_o.
//  Blanking: pixel at (c,r) with c<KERNEL_SIZE-1 or r<KERNEL_SIZE-1 is stored with R=G=B=0.
//   Blanked pixels are still emitted so frame geometry is preserved.
//  Markers stored with pixel: sof=(c==0&&r==0), eol=(c==LINE_WIDTH-1), eof=eol&&(r==FRAME_HEIGHT-1).
//  FIFO entry = {sof,eol,eof,R,G,B}, FWFT. pop = valid_o && ready_i.
//  push = valid_i && (level<FIFO_DEPTH || pop); simultaneous push+pop at full is legal and keeps level.
//  Drop: valid_i=1 when full and no pop: pixel discarded, counters still advance, overflow_o set next edge.
//  Latency: pixel pushed at edge N into empty FIFO is on outputs with valid_o=1 after edge N (1 cycle).
//  Outputs hold stable while valid_o=1 and ready_i=0. When valid_o=0, output data and markers are 0.
//  level_o updates at the edge: +1 push only, -1 pop only, unchanged for both or neither.
//  Read/write pointers wrap modulo FIFO_DEPTH; full is distinguished from empty by the level counter.
// TESTING (LINE_WIDTH=8, FRAME_HEIGHT=4, KERNEL_SIZE=3, FIFO_DEPTH=4 unless noted)
//  1. ready_i=1, 32 pixels R=G=B=index 0..31 -> 32 outputs in order.
//     Cols 0-1 and rows 0-1 read 0; (2,2) reads 18; sof on #0, eol on #7/15/23/31, eof on #31.
//  2. ready_i=0, 5 consecutive pixels -> level_o=4, 5th dropped, overflow_o=1.
//     Then ready_i=1 drains 4 pixels in order and level_o=0.
//  3. FIFO full, ready_i=1 and valid_i=1 same cycle -> push accepted, level_o stays 4, overflow_o stays 0.
//  4. sof_i with valid_i at col 5 row 1 -> that pixel output with sof_o=1; col_o=1,row_o=0 after edge.
//  5. rst with level_o=3, overflow_o=1 mid-frame -> after edge valid_o=0, level_o=0, overflow_o=0, col_o=row_o=0.
//  6. valid_i toggling 1,0,0,1 -> col_o advances only on valid cycles; no outputs inserted for gaps.

Source files
------------

// File: rtl/conv_stream_framer_if.sv
// Pixel stream bundle for the framer: kernel-side input stream plus FWFT output handshake.
interface conv_stream_framer_if #(parameter int PIXEL_DEPTH = 8);
  logic                   sof_i;
  logic                   valid_i;
  logic [PIXEL_DEPTH-1:0] input_R, input_G, input_B;
  logic                   ready_i;
  logic                   valid_o;
  logic [PIXEL_DEPTH-1:0] output_R, output_G, output_B;
  logic                   sof_o, eol_o, eof_o;

  modport master (
    output sof_i, valid_i, input_R, input_G, input_B, ready_i,
    input  valid_o, output_R, output_G, output_B, sof_o, eol_o, eof_o
  );
  modport slave (
    input  sof_i, valid_i, input_R, input_G, input_B, ready_i,
    output valid_o, output_R, output_G, output_B, sof_o, eol_o, eof_o
  );
endinterface

// File: rtl/conv_stream_framer.sv
// Tracks frame position of the kernel output stream, blanks incomplete-window border pixels,
// tags sof/eol/eof and buffers entries in a first-word-fall-through FIFO.
module conv_stream_framer #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIXEL_DEPTH  = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int FIFO_DEPTH   = 16,
  localparam int CW = $clog2(LINE_WIDTH),
  localparam int RW = $clog2(FRAME_HEIGHT),
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_stream_framer_if.slave    bus,
  output logic [CW-1:0]          col_o,
  output logic [RW-1:0]          row_o,
  output logic [LW-1:0]          level_o,
  output logic                   overflow_o
);

  typedef struct packed {
    logic                   sof;
    logic                   eol;
    logic                   eof;
    logic [PIXEL_DEPTH-1:0] r;
    logic [PIXEL_DEPTH-1:0] g;
    logic [PIXEL_DEPTH-1:0] b;
  } entry_t;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        entry_d, head;
  logic          full, pop, push, drop, blank, last_col, last_row;

  // sof_i forces the current pixel to (0,0) regardless of the running counters
  always_comb begin
    cur_col  = bus.sof_i ? '0 : col_q;
    cur_row  = bus.sof_i ? '0 : row_q;
    last_col = (cur_col == CW'(LINE_WIDTH - 1));
    last_row = (cur_row == RW'(FRAME_HEIGHT - 1));
    col_d    = cur_col;
    row_d    = cur_row;
    if (bus.valid_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  always_comb begin
    blank       = (cur_col < CW'(KERNEL_SIZE - 1)) || (cur_row < RW'(KERNEL_SIZE - 1));
    entry_d.sof = (cur_col == '0) && (cur_row == '0);
    entry_d.eol = last_col;
    entry_d.eof = last_col && last_row;
    entry_d.r   = blank ? '0 : bus.input_R;
    entry_d.g   = blank ? '0 : bus.input_G;
    entry_d.b   = blank ? '0 : bus.input_B;
  end

  // Push is allowed at full when the head leaves in the same cycle
  always_comb begin
    full       = (level_q == LW'(FIFO_DEPTH));
    pop        = (level_q != '0) && bus.ready_i;
    push       = bus.valid_i && (!full || pop);
    drop       = bus.valid_i && !push;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = (overflow_q && !bus.sof_i) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is visible
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= entry_d;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    bus.valid_o  = (level_q != '0);
    bus.output_R = bus.valid_o ? head.r   : '0;
    bus.output_G = bus.valid_o ? head.g   : '0;
    bus.output_B = bus.valid_o ? head.b   : '0;
    bus.sof_o    = bus.valid_o ? head.sof : 1'b0;
    bus.eol_o    = bus.valid_o ? head.eol : 1'b0;
    bus.eof_o    = bus.valid_o ? head.eof : 1'b0;
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule
